// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode map, shifter modes,
// flag bit positions, FSM state encoding and opcode classification helpers.
// Optional divider support is enabled with the ALU_DIV_EN macro.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_DIVU = 4'b0110;
  localparam logic [3:0] OP_REMU = 4'b0111;

  localparam logic [2:0] SH_NONE = 3'b000;
  localparam logic [2:0] SH_LSR  = 3'b001;
  localparam logic [2:0] SH_LSL  = 3'b010;
  localparam logic [2:0] SH_ROR  = 3'b011;
  localparam logic [2:0] SH_ASR  = 3'b100;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_ITER = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Opcodes this build actually implements; everything else reports err.
  function automatic logic op_is_legal(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return (op <= OP_REMU);
`else
    return (op <= OP_XOR);
`endif
  endfunction

  // Opcodes that run through the WIDTH-step iterative datapath.
  function automatic logic op_is_iter(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle of the multi-cycle ALU. The master side issues
// requests and consumes results; the slave side is the ALU itself.
interface alu_multicycle_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) ();

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   In1;
  logic [WIDTH-1:0]   In2;
  logic [3:0]         opcode;
  logic [2:0]         SR_Cont;
  logic [SHAMT_W-1:0] SR_Bit;
  logic               S;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   Out;
  logic [3:0]         Flags;
  logic               err;

  modport master (
    output in_valid, In1, In2, opcode, SR_Cont, SR_Bit, S, out_ready,
    input  in_ready, out_valid, Out, Flags, err
  );

  modport slave (
    input  in_valid, In1, In2, opcode, SR_Cont, SR_Bit, S, out_ready,
    output in_ready, out_valid, Out, Flags, err
  );

endinterface

// File: rtl/alu_barrel_shift.sv
// Combinational operand pre-shifter: logarithmic barrel shifter supporting
// LSR, LSL, ROR and ASR. Unknown modes and a zero amount pass din through.
module alu_barrel_shift
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   din,
  input  logic [2:0]         mode,
  input  logic [SHAMT_W-1:0] amt,
  output logic [WIDTH-1:0]   dout
);

  logic [WIDTH-1:0] stage [SHAMT_W+1];

  assign stage[0] = din;

  // Stage gi conditionally shifts by 2**gi, selected by amount bit gi.
  generate
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      localparam int D = 1 << gi;
      logic [WIDTH-1:0] cur;
      logic [WIDTH-1:0] shifted;

      assign cur = stage[gi];
      assign shifted = (mode == SH_LSR) ? (cur >> D) :
                       (mode == SH_LSL) ? (cur << D) :
                       (mode == SH_ROR) ? {cur[D-1:0], cur[WIDTH-1:D]} :
                       (mode == SH_ASR) ? WIDTH'($signed(cur) >>> D) :
                                          cur;
      assign stage[gi+1] = amt[gi] ? shifted : cur;
    end
  endgenerate

  assign dout = stage[SHAMT_W];

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes, operand pre-shifter,
// registered result/NZCV flags and an iterative shift-add multiplier.
// Define ALU_DIV_EN to add the iterative restoring divider (DIVU/REMU).
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  alu_multicycle_if.slave  bus
);

  localparam int CNT_W = SHAMT_W + 1;
  // Counter value at which all WIDTH steps are finished and the result is
  // written, giving WIDTH+1 cycles from accept to out_valid.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       op_reg;
  logic             s_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] iter_a_reg;
  logic [WIDTH-1:0] iter_b_reg;
  logic [WIDTH-1:0] out_reg;
  logic [3:0]       flags_reg;
  logic             err_reg;

  logic [WIDTH-1:0] b_shifted;
  logic             accept;
  logic             finish;
  logic [WIDTH-1:0] acc_step, a_step, b_step;
  logic [WIDTH-1:0] res;
  logic             res_c, res_v, res_legal;

  alu_barrel_shift #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shift (
    .din  (bus.In2),
    .mode (bus.SR_Cont),
    .amt  (bus.SR_Bit),
    .dout (b_shifted)
  );

  assign accept        = bus.in_valid && (state_reg == ST_IDLE);
  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.Out       = out_reg;
  assign bus.Flags     = flags_reg;
  assign bus.err       = err_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; finish marks the edge that writes the result.
  always_comb begin
    state_next = state_reg;
    finish     = 1'b0;
    case (state_reg)
      ST_IDLE: if (accept) state_next = op_is_iter(bus.opcode) ? ST_ITER : ST_EXEC;
      ST_EXEC: begin
        state_next = ST_DONE;
        finish     = 1'b1;
      end
      ST_ITER: if (cnt_reg == CNT_LAST) begin
        state_next = ST_DONE;
        finish     = 1'b1;
      end
      ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef ALU_DIV_EN
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_diff;
`endif

  // One iteration step: shift-add multiply, or restoring divide where the
  // quotient shifts in through iter_a_reg and the remainder lives in acc_reg.
  // A zero divisor naturally yields all-ones quotient and remainder = In1.
  always_comb begin
    acc_step = iter_b_reg[0] ? (acc_reg + iter_a_reg) : acc_reg;
    a_step   = iter_a_reg << 1;
    b_step   = iter_b_reg >> 1;
`ifdef ALU_DIV_EN
    rem_shift = {acc_reg, iter_a_reg[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, iter_b_reg};
    if (op_reg != OP_MUL) begin
      b_step = iter_b_reg;
      if (!rem_diff[WIDTH]) begin
        acc_step = rem_diff[WIDTH-1:0];
        a_step   = {iter_a_reg[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = rem_shift[WIDTH-1:0];
        a_step   = {iter_a_reg[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Request latch and iterative datapath registers.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg      <= bus.In1;
      b_reg      <= b_shifted;
      op_reg     <= bus.opcode;
      s_reg      <= bus.S;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      iter_a_reg <= bus.In1;
      iter_b_reg <= b_shifted;
    end else if (state_reg == ST_ITER && cnt_reg != CNT_LAST) begin
      acc_reg    <= acc_step;
      iter_a_reg <= a_step;
      iter_b_reg <= b_step;
      cnt_reg    <= cnt_reg + 1'b1;
    end
  end

  // Result selection and carry/overflow for the completing operation.
  always_comb begin
    res       = '0;
    res_c     = 1'b0;
    res_v     = 1'b0;
    res_legal = op_is_legal(op_reg);
    case (op_reg)
      OP_ADD: begin
        {res_c, res} = {1'b0, a_reg} + {1'b0, b_reg};
        res_v = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (res[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_SUB: begin
        {res_c, res} = {1'b0, a_reg} + {1'b0, ~b_reg} + (WIDTH+1)'(1);
        res_v = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (res[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_MUL: res = acc_reg;
      OP_OR:  res = a_reg | b_reg;
      OP_AND: res = a_reg & b_reg;
      OP_XOR: res = a_reg ^ b_reg;
`ifdef ALU_DIV_EN
      OP_DIVU: res = iter_a_reg;
      OP_REMU: res = acc_reg;
`endif
      default: res = '0;
    endcase
  end

  // Output registers: written once per operation, flags only when requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg   <= '0;
      flags_reg <= '0;
      err_reg   <= 1'b0;
    end else if (finish) begin
      out_reg <= res_legal ? res : '0;
      err_reg <= !res_legal;
      if (res_legal && s_reg) begin
        flags_reg[FLAG_N] <= res[WIDTH-1];
        flags_reg[FLAG_Z] <= (res == '0);
        flags_reg[FLAG_C] <= res_c;
        flags_reg[FLAG_V] <= res_v;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): directed cases plus
// randomized operations compared against a plain-arithmetic reference model.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 32;
`ifdef ALU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  exp_flags;
  logic [31:0] last_out;
  logic [3:0]  last_flags;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] b, input logic [2:0] mode,
                                            input logic [4:0] amt);
    case (mode)
      3'd1:    return b >> amt;
      3'd2:    return b << amt;
      3'd3:    return (amt == 0) ? b : ((b >> amt) | (b << (32 - amt)));
      3'd4:    return 32'($signed(b) >>> amt);
      default: return b;
    endcase
  endfunction

  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] bp, input logic [3:0] op,
                                  output logic [31:0] r, output logic c, output logic v,
                                  output logic legal);
    longint sa, sb, sr;
    sa = $signed(a);
    sb = $signed(bp);
    r = 0; c = 0; v = 0;
    legal = (op <= 4'd5) || (DIV_ON && op <= 4'd7);
    case (op)
      4'd0: begin
        r = a + bp;
        c = (longint'(a) + longint'(bp)) >= 64'h1_0000_0000;
        sr = sa + sb;
        v = (sr > SMAX) || (sr < SMIN);
      end
      4'd1: begin
        r = a - bp;
        c = (a >= bp);
        sr = sa - sb;
        v = (sr > SMAX) || (sr < SMIN);
      end
      4'd2: r = a * bp;
      4'd3: r = a | bp;
      4'd4: r = a & bp;
      4'd5: r = a ^ bp;
      4'd6: if (DIV_ON) r = (bp == 0) ? 32'hFFFF_FFFF : a / bp;
      4'd7: if (DIV_ON) r = (bp == 0) ? a : a % bp;
      default: r = 0;
    endcase
    if (!legal) r = 0;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [2:0] mode, input logic [4:0] amt, input logic s,
                        input int stall);
    logic [31:0] bp, r;
    logic        c, v, legal;
    int          lat, exp_lat, waitc;
    bp = ref_shift(b, mode, amt);
    ref_alu(a, bp, op, r, c, v, legal);
    exp_lat = (legal && (op == 4'd2 || op == 4'd6 || op == 4'd7)) ? W + 1 : 1;
    if (legal && s) exp_flags = {r[31], (r == 0), c, v};

    waitc = 0;
    while (!bus.in_ready && waitc < 200) begin
      step();
      waitc++;
    end
    check_eq("idle_ready", bus.in_ready, 1'b1);

    bus.in_valid = 1'b1; bus.In1 = a; bus.In2 = b; bus.opcode = op;
    bus.SR_Cont = mode; bus.SR_Bit = amt; bus.S = s; bus.out_ready = 1'b0;
    step();
    // Scramble inputs after acceptance; the DUT must have latched them.
    bus.in_valid = 1'b0; bus.In1 = $urandom; bus.In2 = $urandom;
    bus.opcode = 4'($urandom); bus.SR_Cont = 3'($urandom); bus.SR_Bit = 5'($urandom);
    bus.S = 1'($urandom);

    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus.out_valid && lat < 200);
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("out", bus.Out, r);
    check_eq("err", bus.err, !legal);
    check_eq("flags", bus.Flags, exp_flags);
    last_out   = bus.Out;
    last_flags = bus.Flags;

    for (int k = 0; k < stall; k++) begin
      step();
      check_eq("hold", {bus.out_valid, bus.in_ready, bus.Out}, {1'b1, 1'b0, r});
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_eq("release", {bus.out_valid, bus.in_ready}, 2'b01);
    $display("op=%0d a=%08h b=%08h mode=%0d amt=%0d s=%0d -> out=%08h flags=%04b err=%0d lat=%0d",
             op, a, b, mode, amt, s, last_out, last_flags, !legal, lat);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.In1 = '0; bus.In2 = '0; bus.opcode = '0;
    bus.SR_Cont = '0; bus.SR_Bit = '0; bus.S = 1'b0; bus.out_ready = 1'b0;
    exp_flags = 4'b0000;
    repeat (3) step();
    rst = 1'b0;
    check_eq("rst_state", {bus.out_valid, bus.in_ready, bus.err, bus.Flags, bus.Out},
             {1'b0, 1'b1, 1'b0, 4'b0000, 32'h0});

    // Pre-shifted ADDs.
    run_op(32'd30, 32'd10, OP_ADD, SH_ROR, 5'd4, 1'b1, 0);
    check_eq("add_ror_lit", last_out, 32'hA000_001E);
    check_eq("add_ror_flags_lit", last_flags, 4'b1000);
    run_op(32'd30, 32'd10, OP_ADD, SH_LSL, 5'd4, 1'b1, 1);
    check_eq("add_lsl_lit", last_out, 32'd190);

    // SUB flags, then S=0 must leave flags alone.
    run_op(32'd10, 32'd30, OP_SUB, SH_NONE, 5'd0, 1'b1, 0);
    check_eq("sub_lit", last_out, 32'hFFFF_FFEC);
    check_eq("sub_flags_lit", last_flags, 4'b1000);
    run_op(32'd30, 32'd30, OP_SUB, SH_NONE, 5'd0, 1'b0, 0);
    check_eq("sub_s0_flags_lit", last_flags, 4'b1000);

    // MUL latency with 5 cycles of backpressure.
    run_op(32'd5, 32'd5, OP_MUL, SH_NONE, 5'd0, 1'b1, 5);
    check_eq("mul_lit", last_out, 32'd25);

    // Signed overflow.
    run_op(32'h7FFF_FFFF, 32'd1, OP_ADD, SH_NONE, 5'd0, 1'b1, 0);
    check_eq("ovf_lit", last_out, 32'h8000_0000);
    check_eq("ovf_flags_lit", last_flags, 4'b1001);

    // Divider or illegal opcode 0110.
    if (DIV_ON) begin
      run_op(32'd100, 32'd7, OP_DIVU, SH_NONE, 5'd0, 1'b1, 0);
      check_eq("divu_lit", last_out, 32'd14);
      run_op(32'd100, 32'd7, OP_REMU, SH_NONE, 5'd0, 1'b1, 0);
      check_eq("remu_lit", last_out, 32'd2);
      run_op(32'd1234, 32'd0, OP_DIVU, SH_NONE, 5'd0, 1'b1, 0);
      check_eq("divz_lit", last_out, 32'hFFFF_FFFF);
      run_op(32'd1234, 32'd0, OP_REMU, SH_NONE, 5'd0, 1'b1, 0);
      check_eq("remz_lit", last_out, 32'd1234);
    end else begin
      run_op(32'd100, 32'd7, 4'b0110, SH_NONE, 5'd0, 1'b1, 0);
      check_eq("illegal_err_lit", {bus.err, last_out}, {1'b1, 32'h0});
    end
    run_op(32'd1, 32'd2, 4'b1011, SH_NONE, 5'd0, 1'b1, 2);

    // Reset during MUL iteration: the partial result must never appear.
    bus.in_valid = 1'b1; bus.In1 = 32'd5; bus.In2 = 32'd5; bus.opcode = OP_MUL;
    bus.SR_Cont = SH_NONE; bus.SR_Bit = '0; bus.S = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_flags = 4'b0000;
    check_eq("midrst_state", {bus.out_valid, bus.in_ready, bus.Flags, bus.Out},
             {1'b0, 1'b1, 4'b0000, 32'h0});
    seen = 0;
    repeat (40) begin
      step();
      if (bus.out_valid) seen++;
    end
    check_eq("midrst_no_stale", 64'(seen), 64'd0);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      int          sel;
      logic [3:0]  op;
      sel = $urandom_range(0, 9);
      op  = (sel < 8) ? 4'(sel) : 4'($urandom_range(8, 15));
      run_op(rand_operand(), rand_operand(), op, 3'($urandom_range(0, 7)),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
